// File: rtl/div_share_ctrl.sv
// Two-requester front end for an iterative restoring unsigned divider.
// Round-robin grant, WIDTH shift/subtract iterations, valid/ready response tagged with requester id.
module div_share_ctrl #(
   parameter int WIDTH = 5
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_dividend,
   input  logic [WIDTH-1:0] req0_divisor,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_dividend,
   input  logic [WIDTH-1:0] req1_divisor,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_quotient,
   output logic [WIDTH-1:0] rsp_remainder,
   output logic             rsp_div_zero,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

   state_t           r_state, w_next_state;
   logic             r_last_grant, r_id;
   logic [WIDTH:0]   r_a;
   logic [WIDTH-1:0] r_q, r_b;
   logic [CW-1:0]    r_count;

   logic             w_grant, w_accept, w_last_iter;
   logic [WIDTH-1:0] w_dividend, w_divisor, w_q_shift;
   logic [WIDTH:0]   w_a_shift, w_t, w_a_next;

   // Handshakes: a transfer happens on the rising edge where valid && ready are both high.
   // Requesters: ready is combinational on valid, so a requester may withdraw freely before it.
   // Response: rsp_* hold from DONE entry until the edge with rsp_ready high.
   always_comb begin
      w_grant = 1'b0;
      if (req0_valid && req1_valid) w_grant = ~r_last_grant;
      else if (req1_valid)          w_grant = 1'b1;
   end

   assign w_accept    = (r_state == S_IDLE) && (req0_valid || req1_valid);
   assign w_dividend  = w_grant ? req1_dividend : req0_dividend;
   assign w_divisor   = w_grant ? req1_divisor  : req0_divisor;
   assign w_last_iter = (r_count == CW'(1));

   // A stays below B between iterations, so its top bit can be dropped before the shift.
   assign w_a_shift = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
   assign w_t       = w_a_shift - {1'b0, r_b};
   assign w_a_next  = w_t[WIDTH] ? w_a_shift : w_t;
   assign w_q_shift = {r_q[WIDTH-2:0], ~w_t[WIDTH]};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next_state = (w_divisor == '0) ? S_DONE : S_ITER;
         S_ITER: if (w_last_iter) w_next_state = S_DONE;
         S_DONE: if (rsp_ready) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      req0_ready = (r_state == S_IDLE) && req0_valid && !w_grant;
      req1_ready = (r_state == S_IDLE) && req1_valid && w_grant;
      rsp_valid  = (r_state == S_DONE);
      busy       = (r_state != S_IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_last_grant  <= 1'b1;
         r_id          <= 1'b0;
         r_a           <= '0;
         r_q           <= '0;
         r_b           <= '0;
         r_count       <= '0;
         rsp_id        <= 1'b0;
         rsp_quotient  <= '0;
         rsp_remainder <= '0;
         rsp_div_zero  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_b          <= w_divisor;
                  r_q          <= w_dividend;
                  r_a          <= '0;
                  r_count      <= CW'(WIDTH);
                  r_id         <= w_grant;
                  r_last_grant <= w_grant;
                  if (w_divisor == '0) begin
                     rsp_id        <= w_grant;
                     rsp_quotient  <= '1;
                     rsp_remainder <= w_dividend;
                     rsp_div_zero  <= 1'b1;
                  end
               end
            end
            S_ITER: begin
               r_a     <= w_a_next;
               r_q     <= w_q_shift;
               r_count <= r_count - CW'(1);
               if (w_last_iter) begin
                  rsp_id        <= r_id;
                  rsp_quotient  <= w_q_shift;
                  rsp_remainder <= w_a_next[WIDTH-1:0];
                  rsp_div_zero  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
